// File: rtl/core_pkg.sv
// Shared core definitions: sequencing-controller states, register zero, default trap vector.
package core_pkg;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StMdWait = 2'd1,
    StTrap   = 2'd2
  } hz_state_e;

  localparam logic [4:0]  REG_ZERO         = 5'd0;
  localparam logic [31:0] TRAP_VEC_DEFAULT = 32'h0000_0004;

endpackage

// File: rtl/lu_detect.sv
// Load-use comparator: flags an ID instruction that reads the destination of a load in EX.
module lu_detect
  import core_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_is_load,
  output logic       lu_hit
);

  // x0 never carries a real dependency, so a load to it cannot cause a hazard.
  always_comb begin
    lu_hit = ex_is_load && (ex_rd != REG_ZERO) &&
             ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: pause/flush for PC, IF/ID, ID/EX and EX/MEM covering
// load-use, taken branches, multi-cycle mul/div occupancy and interrupt entry.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int unsigned MD_CYCLES = 32,  // must be >= 2 and <= 64
  parameter logic [31:0] TRAP_VEC  = TRAP_VEC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_is_load,
  input  logic        ex_branch_taken,
  input  logic        ex_md_start,
  input  logic        irq,
  output logic        pc_pause,
  output logic        pc_flush,
  output logic        ifid_pause,
  output logic        ifid_flush,
  output logic        idex_pause,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        trap_sel,
  output logic [31:0] trap_pc,
  output logic        irq_ack,
  output logic        md_busy
);

  localparam logic [5:0] MD_LOAD = 6'(MD_CYCLES - 1);

  hz_state_e  state_q;
  logic [5:0] md_cnt_q;
  logic       irq_pend_q;
  logic       lu_hit;
  logic       pc_pause_raw, ifid_pause_raw, idex_pause_raw;

  lu_detect u_lu_detect (
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_rd      (ex_rd),
    .ex_is_load (ex_is_load),
    .lu_hit     (lu_hit)
  );

  assign trap_pc = TRAP_VEC;

  // Sequencing FSM: state, mul/div down-counter and pending-interrupt latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StRun;
      md_cnt_q   <= 6'd0;
      irq_pend_q <= 1'b0;
    end else begin
      case (state_q)
        StRun: begin
          irq_pend_q <= irq_pend_q | irq;
          if (ex_branch_taken) begin
            // Branch wins; a mul/div in the shadow of the branch is squashed.
          end else if (ex_md_start) begin
            md_cnt_q <= MD_LOAD;
            state_q  <= StMdWait;
          end else if (lu_hit) begin
            // Single bubble, no state change.
          end else if (irq_pend_q) begin
            irq_pend_q <= 1'b0;
            state_q    <= StTrap;
          end
        end
        StMdWait: begin
          irq_pend_q <= irq_pend_q | irq;
          md_cnt_q   <= md_cnt_q - 6'd1;
          if (md_cnt_q == 6'd1) state_q <= StRun;
        end
        StTrap: begin
          // Source drops irq in response to irq_ack, so do not relatch during entry.
          irq_pend_q <= 1'b0;
          state_q    <= StRun;
        end
        default: state_q <= StRun;
      endcase
    end
  end

  // Output decode from current state and EX/ID inputs; everything quiet during reset.
  always_comb begin
    pc_pause_raw   = 1'b0;
    ifid_pause_raw = 1'b0;
    idex_pause_raw = 1'b0;
    pc_flush       = 1'b0;
    ifid_flush     = 1'b0;
    idex_flush     = 1'b0;
    exmem_flush    = 1'b0;
    trap_sel       = 1'b0;
    irq_ack        = 1'b0;
    md_busy        = 1'b0;
    if (!rst) begin
      case (state_q)
        StRun: begin
          if (ex_branch_taken) begin
            pc_flush   = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (ex_md_start) begin
            pc_pause_raw   = 1'b1;
            ifid_pause_raw = 1'b1;
            idex_pause_raw = 1'b1;
            exmem_flush    = 1'b1;
          end else if (lu_hit) begin
            pc_pause_raw   = 1'b1;
            ifid_pause_raw = 1'b1;
            idex_flush     = 1'b1;
          end
        end
        StMdWait: begin
          md_busy        = 1'b1;
          pc_pause_raw   = 1'b1;
          ifid_pause_raw = 1'b1;
          idex_pause_raw = 1'b1;
          exmem_flush    = 1'b1;
        end
        StTrap: begin
          trap_sel    = 1'b1;
          pc_flush    = 1'b1;
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
          irq_ack     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A flushed register is never also held.
  assign pc_pause   = pc_pause_raw & ~pc_flush;
  assign ifid_pause = ifid_pause_raw & ~ifid_flush;
  assign idex_pause = idex_pause_raw & ~idex_flush;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with MD_CYCLES=4.
module tb_hazard_ctrl;

  // Packed output order: pc_pause pc_flush ifid_pause ifid_flush idex_pause idex_flush
  //                      exmem_flush trap_sel irq_ack md_busy
  localparam logic [9:0] PCP = 10'b10_0000_0000;
  localparam logic [9:0] PCF = 10'b01_0000_0000;
  localparam logic [9:0] IFP = 10'b00_1000_0000;
  localparam logic [9:0] IFF = 10'b00_0100_0000;
  localparam logic [9:0] IDP = 10'b00_0010_0000;
  localparam logic [9:0] IDF = 10'b00_0001_0000;
  localparam logic [9:0] EMF = 10'b00_0000_1000;
  localparam logic [9:0] TSL = 10'b00_0000_0100;
  localparam logic [9:0] ACK = 10'b00_0000_0010;
  localparam logic [9:0] MDB = 10'b00_0000_0001;

  localparam logic [9:0] O_NONE = 10'd0;
  localparam logic [9:0] O_LU   = PCP | IFP | IDF;
  localparam logic [9:0] O_BR   = PCF | IFF | IDF;
  localparam logic [9:0] O_MDS  = PCP | IFP | IDP | EMF;
  localparam logic [9:0] O_MDW  = PCP | IFP | IDP | EMF | MDB;
  localparam logic [9:0] O_TRAP = TSL | PCF | IFF | IDF | EMF | ACK;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_is_load, ex_branch_taken, ex_md_start, irq;
  logic        pc_pause, pc_flush, ifid_pause, ifid_flush, idex_pause, idex_flush;
  logic        exmem_flush, trap_sel, irq_ack, md_busy;
  logic [31:0] trap_pc;
  logic [9:0]  outs;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .MD_CYCLES (4),
    .TRAP_VEC  (32'h0000_0004)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .ex_rd           (ex_rd),
    .ex_is_load      (ex_is_load),
    .ex_branch_taken (ex_branch_taken),
    .ex_md_start     (ex_md_start),
    .irq             (irq),
    .pc_pause        (pc_pause),
    .pc_flush        (pc_flush),
    .ifid_pause      (ifid_pause),
    .ifid_flush      (ifid_flush),
    .idex_pause      (idex_pause),
    .idex_flush      (idex_flush),
    .exmem_flush     (exmem_flush),
    .trap_sel        (trap_sel),
    .trap_pc         (trap_pc),
    .irq_ack         (irq_ack),
    .md_busy         (md_busy)
  );

  assign outs = {pc_pause, pc_flush, ifid_pause, ifid_flush, idex_pause, idex_flush,
                 exmem_flush, trap_sel, irq_ack, md_busy};

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2, rd;
    logic       use1, use2, load, br, md;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic use1, input logic use2, input logic load,
                        input logic br, input logic md, input logic irq_v);
    id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd;
    id_use_rs1 = use1; id_use_rs2 = use2; ex_is_load = load;
    ex_branch_taken = br; ex_md_start = md; irq = irq_v;
  endtask

  task automatic clear_in();
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Sample at the falling edge of the current cycle, then advance past the next rising edge.
  task automatic cyc_check(input string name, input logic [9:0] exp);
    @(negedge clk);
    n_checks++;
    if (outs === exp) n_pass++;
    else $display("FAIL %s: got %b want %b", name, outs, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic check_trap_pc(input string name);
    n_checks++;
    if (trap_pc === 32'h0000_0004) n_pass++;
    else $display("FAIL %s: got %h want %h", name, trap_pc, 32'h0000_0004);
  endtask

  initial begin
    vecs[0]  = '{"idle",          5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, O_NONE};
    vecs[1]  = '{"lu_rs1",        5'd5, 5'd1, 5'd5, 1, 1, 1, 0, 0, O_LU};
    vecs[2]  = '{"lu_release",    5'd5, 5'd1, 5'd9, 1, 1, 0, 0, 0, O_NONE};
    vecs[3]  = '{"lu_rd_zero",    5'd0, 5'd0, 5'd0, 1, 1, 1, 0, 0, O_NONE};
    vecs[4]  = '{"lu_rs2",        5'd3, 5'd7, 5'd7, 1, 1, 1, 0, 0, O_LU};
    vecs[5]  = '{"lu_rs2_unused", 5'd3, 5'd7, 5'd7, 1, 0, 1, 0, 0, O_NONE};
    vecs[6]  = '{"match_no_load", 5'd7, 5'd7, 5'd7, 1, 1, 0, 0, 0, O_NONE};
    vecs[7]  = '{"branch",        5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, O_BR};
    vecs[8]  = '{"branch_lu",     5'd5, 5'd0, 5'd5, 1, 0, 1, 1, 0, O_BR};
    vecs[9]  = '{"branch_md",     5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, O_BR};
    vecs[10] = '{"after_br_md",   5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, O_NONE};

    // Reset: outputs stay quiet even with a branch and a mul/div on the inputs.
    rst = 1'b1;
    set_in(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;
    cyc_check("reset_quiet", O_NONE);
    check_trap_pc("reset_trap_pc");
    clear_in();
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      set_in(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].use1, vecs[i].use2,
             vecs[i].load, vecs[i].br, vecs[i].md, 1'b0);
      cyc_check(vecs[i].name, vecs[i].exp);
    end

    // Mul/div: 4 stall cycles, md_busy on the last 3; irq pulse and branch/load-use ignored.
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc_check("md_start", O_MDS);
    set_in(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc_check("md_wait1", O_MDW);
    set_in(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc_check("md_wait2", O_MDW);
    cyc_check("md_wait3", O_MDW);
    clear_in();
    cyc_check("md_release", O_NONE);
    cyc_check("md_irq_trap", O_TRAP);
    check_trap_pc("trap_pc");
    cyc_check("after_trap", O_NONE);
    cyc_check("no_retrap", O_NONE);

    // Interrupt from RUN: two-cycle latency to irq_ack.
    irq = 1'b1;
    cyc_check("irq_c0", O_NONE);
    irq = 1'b0;
    cyc_check("irq_c1", O_NONE);
    cyc_check("irq_ack", O_TRAP);
    cyc_check("irq_done", O_NONE);

    // Pending interrupt yields to a load-use stall, then traps.
    irq = 1'b1;
    cyc_check("irq2_c0", O_NONE);
    set_in(5'd4, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc_check("irq2_lu_first", O_LU);
    clear_in();
    cyc_check("irq2_eligible", O_NONE);
    cyc_check("irq2_trap", O_TRAP);

    // Reset in MD_WAIT cycle 2 aborts the mul/div and drops the pending interrupt.
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc_check("md2_start", O_MDS);
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc_check("md2_wait1", O_MDW);
    clear_in();
    rst = 1'b1;
    cyc_check("md2_rst", O_NONE);
    rst = 1'b0;
    cyc_check("post_rst_run", O_NONE);
    cyc_check("post_rst_no_ack", O_NONE);
    ex_md_start = 1'b1;
    cyc_check("md3_start", O_MDS);
    ex_md_start = 1'b0;
    cyc_check("md3_wait1", O_MDW);
    cyc_check("md3_wait2", O_MDW);
    cyc_check("md3_wait3", O_MDW);
    cyc_check("md3_release", O_NONE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the five-stage core. It generates the pause/flush controls for the PC register and the IF/ID, ID/EX and EX/MEM pipeline registers, and resolves four conditions: load-use hazards, taken branches, multi-cycle mul/div occupancy, and external interrupt entry. It sits beside the decode/execute stages and drives the `pause`/`flush` inputs of the PC and stage registers.

## Interface
- `MD_CYCLES`, default 32: EX-stage occupancy in cycles of one mul/div operation; must be ≥2.
- `TRAP_VEC`, default 32'h0000_0004: trap entry address, driven on `trap_pc`.
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `id_rs1`, `id_rs2`  in  5 each  source registers of the instruction in ID
- `id_use_rs1`, `id_use_rs2`  in  1 each  ID instruction actually reads rs1 / rs2
- `ex_rd`  in  5  destination register of the instruction in EX
- `ex_is_load`  in  1  EX instruction is a load
- `ex_branch_taken`  in  1  EX branch/jump resolved taken
- `ex_md_start`  in  1  EX instruction is a mul/div (first EX cycle)
- `irq`  in  1  external interrupt request, level
- `pc_pause`, `pc_flush`  out  1 each  PC hold / forced load of next_pc
- `ifid_pause`, `ifid_flush`  out  1 each  IF/ID hold / bubble
- `idex_pause`, `idex_flush`  out  1 each  ID/EX hold / bubble
- `exmem_flush`  out  1  EX/MEM bubble
- `trap_sel`  out  1  next_pc mux selects `trap_pc`
- `trap_pc`  out  32  constant `TRAP_VEC`
- `irq_ack`  out  1  one-cycle pulse on trap entry
- `md_busy`  out  1  mul/div in progress

## Operation
- States: RUN, MD_WAIT, TRAP. Registers: state, 6-bit down-counter `md_cnt`, `irq_pend`.
- `irq_pend` is set by `irq` in any cycle and cleared on entry to TRAP.
- Conditions evaluated in RUN, in priority order:
  1. **Branch.** If `ex_branch_taken`: `pc_flush`, `ifid_flush`, `idex_flush`. State stays RUN. `ex_md_start` is ignored in this cycle.
  2. **Mul/div start.** Else if `ex_md_start`: load `md_cnt` = MD_CYCLES-1 and go to MD_WAIT. In the same cycle assert `pc_pause`, `ifid_pause`, `idex_pause`, `exmem_flush`.
  3. **Load-use.** Else if `ex_is_load` and `ex_rd`≠0 and ((`id_use_rs1` and `id_rs1`==`ex_rd`) or (`id_use_rs2` and `id_rs2`==`ex_rd`)): `pc_pause`, `ifid_pause`, `idex_flush` for one cycle.
  4. **Interrupt.** Else if `irq_pend`: go to TRAP. No stall outputs in this cycle.
- MD_WAIT:
  - `md_busy`=1. Assert `pc_pause`, `ifid_pause`, `idex_pause`, `exmem_flush`.
  - `md_cnt` decrements each cycle. When `md_cnt`==1, go to RUN with no pause in the following cycle, so the result advances to MEM.
  - Branch, load-use and irq inputs are ignored; `irq_pend` still latches.
- TRAP (one cycle):
  - Assert `trap_sel`, `pc_flush`, `ifid_flush`, `idex_flush`, `exmem_flush`, `irq_ack`.
  - Clear `irq_pend`. Return to RUN.
- Flush and pause are never asserted together on the same register. Flush wins.
- All stall/flush outputs are combinational from the current state and inputs; state, counter and pending bit are registered.

## Timing
- Reset: state=RUN, `md_cnt`=0, `irq_pend`=0.
  - All outputs are 0 while `rst` is high, except `trap_pc` (constant).
  - Reset mid-MD_WAIT or mid-TRAP aborts immediately. No `irq_ack` follows.
- Branch and load-use controls are asserted in the same cycle as the causing inputs.
- Load-use costs exactly 1 bubble cycle.
- Mul/div stalls the front end for exactly MD_CYCLES cycles, counting the `ex_md_start` cycle.
- Interrupt: `irq` rising at edge N sets `irq_pend` at N+1. TRAP occupies the cycle after the first eligible RUN cycle.
  - Minimum latency from `irq` assertion to `irq_ack`: 2 cycles.
  - `irq` held high re-triggers after return to RUN. The source must deassert on `irq_ack`.
- `ex_branch_taken` and a load-use match in the same cycle: branch only, no pause.

## Structure
- Shared package `core_pkg`: state enum (RUN/MD_WAIT/TRAP), `REG_ZERO`=5'd0, default `TRAP_VEC`.
- The load-use comparator is a natural sub-module, `lu_detect`: purely combinational, inputs id/ex fields, output `lu_hit`.
- The rest is a single FSM process plus an output decode.

## Test plan
- Load x5, next instruction `add x6,x5,x1` (`id_use_rs1`=1, `id_rs1`=5, `ex_rd`=5) → one cycle of `pc_pause`=`ifid_pause`=`idex_flush`=1, then all 0. Repeat with `ex_rd`=0 → no stall.
- `ex_md_start`=1 with MD_CYCLES=4 → `pc_pause`/`idex_pause`/`exmem_flush` high for exactly 4 cycles and `md_busy` high for 3 cycles, then released.
- `ex_branch_taken`=1 together with a load-use match → `pc_flush`, `ifid_flush`, `idex_flush`=1 and `pc_pause`=0.
- `irq` pulsed for 1 cycle during MD_WAIT → no trap until MD_WAIT ends. Then one TRAP cycle with `trap_sel`=1 and `irq_ack`=1, `trap_pc`=32'h4.
- `rst` asserted in cycle 2 of MD_WAIT → next cycle state RUN, all outputs 0. A subsequent `ex_md_start` restarts the full MD_CYCLES count.
